// File: rtl/spi_master.sv
// spi_master: SPI mode-0 master, one BUFFER_SIZE-bit frame per start request.
//   MSB first. MOSI is shifted out of tx_shift; MISO is shifted into rx_shift.
//   A received frame is committed to rx_data only if its top 32 bits equal MSGID.
//   Otherwise rx_err pulses instead.
//
// Ports
//   clk       system clock
//   rst_n     synchronous reset, active low
//   start     frame request, accepted only while busy=0; tx_data latched then
//   tx_data   frame to transmit
//   rx_data   last frame received with a matching MSGID
//   rx_valid  1-cycle pulse, rx_data updated
//   rx_err    1-cycle pulse, frame ended with MSGID mismatch
//   busy      high from the accepting cycle until IDLE is re-entered
//   SPI_SCK   serial clock (idles low)
//   SPI_SSEL  chip select (active low)
//   SPI_MOSI  serial data out
//   SPI_MISO  serial data in (sampled directly on clk)
module spi_master #(
  parameter int          BUFFER_SIZE = 64,
  parameter logic [31:0] MSGID       = 32'h74697277,
  parameter int          CLK_DIV     = 4,
  parameter int          CS_SETUP    = 4,
  parameter int          CS_HOLD     = 4,
  parameter int          CS_IDLE     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [BUFFER_SIZE-1:0] tx_data,
  output logic [BUFFER_SIZE-1:0] rx_data,
  output logic                   rx_valid,
  output logic                   rx_err,
  output logic                   busy,
  output logic                   SPI_SCK,
  output logic                   SPI_SSEL,
  output logic                   SPI_MOSI,
  input  logic                   SPI_MISO
);

  localparam int BC_W   = $clog2(BUFFER_SIZE + 1);
  localparam int HC_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int WMAX_A = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int WMAX   = (WMAX_A > CS_IDLE) ? WMAX_A : CS_IDLE;
  localparam int WC_W   = $clog2(WMAX + 1);

  localparam logic [HC_W-1:0] HC_LAST    = HC_W'(CLK_DIV - 1);
  localparam logic [BC_W-1:0] BC_LAST    = BC_W'(BUFFER_SIZE);
  localparam logic [WC_W-1:0] SETUP_LAST = WC_W'(CS_SETUP - 1);
  localparam logic [WC_W-1:0] HOLD_LAST  = WC_W'(CS_HOLD - 1);
  // The IDLE cycle itself counts as one SSEL-high cycle, so the gap state
  // lasts CS_IDLE-1 cycles and back-to-back frames see exactly CS_IDLE.
  localparam logic [WC_W-1:0] GAP_LAST   = WC_W'((CS_IDLE >= 2) ? CS_IDLE - 2 : 0);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_XFER  = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  logic [2:0]             state;
  logic [HC_W-1:0]        hcnt;
  logic [BC_W-1:0]        bitcnt;
  logic [WC_W-1:0]        wcnt;
  logic [BUFFER_SIZE-1:0] tx_shift;
  logic [BUFFER_SIZE-1:0] rx_shift;

  logic accept;
  logic sck_rise;
  logic sck_fall;

  function automatic logic msgid_match(input logic [31:0] hdr);
    return hdr == MSGID;
  endfunction

  assign accept   = (state == ST_IDLE) && start;
  assign sck_rise = (state == ST_XFER) && (hcnt == HC_LAST) && !SPI_SCK;
  assign sck_fall = (state == ST_XFER) && (hcnt == HC_LAST) && SPI_SCK;

  // Shift registers carry data only and need no reset.
  always_ff @(posedge clk) begin
    if (accept)
      tx_shift <= tx_data;
    else if (sck_fall && (bitcnt != BC_LAST))
      tx_shift <= {tx_shift[BUFFER_SIZE-2:0], 1'b0};
    if (sck_rise)
      rx_shift <= {rx_shift[BUFFER_SIZE-2:0], SPI_MISO};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      hcnt     <= '0;
      bitcnt   <= '0;
      wcnt     <= '0;
      SPI_SCK  <= 1'b0;
      SPI_SSEL <= 1'b1;
      SPI_MOSI <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_SETUP;
            busy     <= 1'b1;
            SPI_SSEL <= 1'b0;
            SPI_MOSI <= tx_data[BUFFER_SIZE-1];
            wcnt     <= '0;
          end
        end
        ST_SETUP: begin
          if (wcnt == SETUP_LAST) begin
            state  <= ST_XFER;
            wcnt   <= '0;
            hcnt   <= '0;
            bitcnt <= '0;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        ST_XFER: begin
          if (hcnt == HC_LAST) begin
            hcnt    <= '0;
            SPI_SCK <= ~SPI_SCK;
            if (!SPI_SCK) begin
              bitcnt <= bitcnt + 1'b1;
            end else if (bitcnt == BC_LAST) begin
              // Last falling edge of the frame.
              SPI_MOSI <= 1'b0;
              state    <= ST_HOLD;
              wcnt     <= '0;
            end else begin
              SPI_MOSI <= tx_shift[BUFFER_SIZE-2];
            end
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (wcnt == HOLD_LAST) begin
            SPI_SSEL <= 1'b1;
            wcnt     <= '0;
            if (msgid_match(rx_shift[BUFFER_SIZE-1 -: 32])) begin
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
            end else begin
              rx_err <= 1'b1;
            end
            if (CS_IDLE > 1) begin
              state <= ST_GAP;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (wcnt == GAP_LAST) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            wcnt  <= '0;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed bench for spi_master.
//   dut  : default parameters (64-bit frame, CLK_DIV=4)
//   dut2 : BUFFER_SIZE=48, CLK_DIV=5
// Each DUT is paired with a behavioural mode-0 slave that returns a reply
// word, captures MOSI, and measures SSEL/SCK timing on the falling clk edge.
module tb_spi_master;

  localparam logic [31:0] MSGID = 32'h74697277;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, start2;
  logic [63:0] tx_data, rx_data;
  logic [47:0] tx_data2, rx_data2;
  logic        rx_valid, rx_err, busy, sck, ssel, mosi;
  logic        rx_valid2, rx_err2, busy2, sck2, ssel2, mosi2;
  logic        miso = 1'b0;
  logic        miso2 = 1'b0;

  spi_master dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err), .busy(busy),
    .SPI_SCK(sck), .SPI_SSEL(ssel), .SPI_MOSI(mosi), .SPI_MISO(miso)
  );

  spi_master #(.BUFFER_SIZE(48), .CLK_DIV(5)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .tx_data(tx_data2),
    .rx_data(rx_data2), .rx_valid(rx_valid2), .rx_err(rx_err2), .busy(busy2),
    .SPI_SCK(sck2), .SPI_SSEL(ssel2), .SPI_MOSI(mosi2), .SPI_MISO(miso2)
  );

  int total  = 0;
  int passes = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Slave model for dut
  logic [63:0] reply = '0;
  logic [63:0] rep_sh = '0;
  logic [63:0] mosi_cap = '0;
  int rises = 0, falls = 0, low_cnt = 0, last_low = 0, hi_cnt = 0;
  int frames = 0, nvalid = 0, nerr = 0;
  logic rise_pulse = 1'b0;
  logic sck_q = 1'b0, ssel_q = 1'b1;
  int gaps[$];

  always @(negedge clk) begin
    if (ssel_q === 1'b1 && ssel === 1'b0) begin
      gaps.push_back(hi_cnt);
      hi_cnt = 0; rep_sh = reply; miso = reply[63];
      rises = 0; falls = 0; mosi_cap = '0; low_cnt = 0;
    end
    if (ssel === 1'b0) low_cnt++; else hi_cnt++;
    if (sck === 1'b1 && sck_q === 1'b0) begin
      mosi_cap = {mosi_cap[62:0], mosi}; rises++;
    end
    if (sck === 1'b0 && sck_q === 1'b1) begin
      falls++; rep_sh = {rep_sh[62:0], 1'b0}; miso = rep_sh[63];
    end
    if (ssel === 1'b1 && ssel_q === 1'b0) begin
      last_low = low_cnt; frames++; rise_pulse = rx_valid | rx_err;
    end
    if (rx_valid === 1'b1) nvalid++;
    if (rx_err === 1'b1) nerr++;
    sck_q = sck; ssel_q = ssel;
  end

  // Slave model for dut2, also tracks SCK period in clk cycles
  logic [47:0] reply2 = '0;
  logic [47:0] rep_sh2 = '0;
  logic [47:0] mosi_cap2 = '0;
  int rises2 = 0, falls2 = 0, low_cnt2 = 0, last_low2 = 0, nvalid2 = 0, nerr2 = 0;
  int cyc = 0, last_rise_cyc = 0, per_min = 0, per_max = 0;
  logic sck2_q = 1'b0, ssel2_q = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (ssel2_q === 1'b1 && ssel2 === 1'b0) begin
      rep_sh2 = reply2; miso2 = reply2[47];
      rises2 = 0; falls2 = 0; mosi_cap2 = '0; low_cnt2 = 0;
      per_min = 100000; per_max = 0;
    end
    if (ssel2 === 1'b0) low_cnt2++;
    if (sck2 === 1'b1 && sck2_q === 1'b0) begin
      if (rises2 > 0) begin
        if (cyc - last_rise_cyc < per_min) per_min = cyc - last_rise_cyc;
        if (cyc - last_rise_cyc > per_max) per_max = cyc - last_rise_cyc;
      end
      last_rise_cyc = cyc;
      mosi_cap2 = {mosi_cap2[46:0], mosi2}; rises2++;
    end
    if (sck2 === 1'b0 && sck2_q === 1'b1) begin
      falls2++; rep_sh2 = {rep_sh2[46:0], 1'b0}; miso2 = rep_sh2[47];
    end
    if (ssel2 === 1'b1 && ssel2_q === 1'b0) last_low2 = low_cnt2;
    if (rx_valid2 === 1'b1) nvalid2++;
    if (rx_err2 === 1'b1) nerr2++;
    sck2_q = sck2; ssel2_q = ssel2;
  end

  task automatic wait_idle1();
    int n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge clk); n++;
    end
    chk("busy1_done", busy, 1'b0);
  endtask

  task automatic wait_idle2();
    int n = 0;
    while (busy2 !== 1'b0 && n < 3000) begin
      @(negedge clk); n++;
    end
    chk("busy2_done", busy2, 1'b0);
  endtask

  task automatic run1(input logic [63:0] tx);
    @(negedge clk); tx_data = tx; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_idle1();
  endtask

  task automatic run2(input logic [47:0] tx);
    @(negedge clk); tx_data2 = tx; start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    wait_idle2();
  endtask

  int f0, v0, e0, n;

  initial begin
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; tx_data = '0; tx_data2 = '0;
    repeat (4) @(negedge clk);
    chk("rst_sck", sck, 1'b0);
    chk("rst_ssel", ssel, 1'b1);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_rx_data", rx_data, 64'h0);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx_err", rx_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Good frame with loopback reply
    reply = {MSGID, 32'h12345678};
    v0 = nvalid; e0 = nerr;
    run1(64'hA5A5_0000_FFFF_0001);
    chk("t1_mosi", mosi_cap, 64'hA5A5_0000_FFFF_0001);
    chk("t1_rx_data", rx_data, {MSGID, 32'h12345678});
    chk("t1_valid_cnt", nvalid - v0, 1);
    chk("t1_err_cnt", nerr - e0, 0);
    chk("t1_rises", rises, 64);
    chk("t1_falls", falls, 64);
    chk("t1_ssel_low", last_low, 520);
    chk("t1_pulse_at_ssel_rise", rise_pulse, 1'b1);

    // MSGID mismatch
    reply = 64'hDEADBEEF_00000001;
    v0 = nvalid; e0 = nerr;
    run1(64'h0123_4567_89AB_CDEF);
    chk("t2_err_cnt", nerr - e0, 1);
    chk("t2_valid_cnt", nvalid - v0, 0);
    chk("t2_rx_data_kept", rx_data, {MSGID, 32'h12345678});
    chk("t2_mosi", mosi_cap, 64'h0123_4567_89AB_CDEF);

    // start pulsed while busy, tx_data changed mid-frame
    reply = {MSGID, 32'hCAFE0003};
    f0 = frames;
    @(negedge clk); tx_data = 64'h1111_2222_3333_4444; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    tx_data = 64'h9999_8888_7777_6666; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_idle1();
    repeat (20) @(negedge clk);
    chk("t3_frames", frames - f0, 1);
    chk("t3_busy", busy, 1'b0);
    chk("t3_ssel_low", last_low, 520);
    chk("t3_mosi", mosi_cap, 64'h1111_2222_3333_4444);
    chk("t3_rx_data", rx_data, {MSGID, 32'hCAFE0003});

    // start held high for three frames
    reply = {MSGID, 32'h00000004};
    gaps.delete();
    f0 = frames; v0 = nvalid;
    @(negedge clk); tx_data = 64'h5555_AAAA_5555_AAAA; start = 1'b1;
    n = 0;
    while (frames - f0 < 3 && n < 5000) begin
      @(negedge clk); n++;
    end
    start = 1'b0;
    wait_idle1();
    repeat (30) @(negedge clk);
    chk("t4_frames", frames - f0, 3);
    chk("t4_valid_cnt", nvalid - v0, 3);
    chk("t4_gap_count", gaps.size(), 3);
    if (gaps.size() >= 3) begin
      chk("t4_gap1", gaps[1], 8);
      chk("t4_gap2", gaps[2], 8);
    end

    // Reset in the middle of a frame
    reply = {MSGID, 32'h0BADF00D};
    v0 = nvalid; e0 = nerr;
    @(negedge clk); tx_data = 64'hFEDC_BA98_7654_3210; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (rises < 20 && n < 3000) begin
      @(negedge clk); n++;
    end
    chk("t5_reached_rise20", rises >= 20, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_ssel", ssel, 1'b1);
    chk("t5_sck", sck, 1'b0);
    chk("t5_mosi", mosi, 1'b0);
    chk("t5_rx_data", rx_data, 64'h0);
    chk("t5_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("t5_no_valid", nvalid - v0, 0);
    chk("t5_no_err", nerr - e0, 0);
    run1(64'h0F0F_F0F0_0F0F_F0F0);
    chk("t5_rx_data_after", rx_data, {MSGID, 32'h0BADF00D});
    chk("t5_valid_after", nvalid - v0, 1);
    chk("t5_mosi_after", mosi_cap, 64'h0F0F_F0F0_0F0F_F0F0);

    // 48-bit frame, CLK_DIV=5
    reply2 = {MSGID, 16'hBEEF};
    run2(48'h1234_5678_9ABC);
    chk("t6_rises", rises2, 48);
    chk("t6_falls", falls2, 48);
    chk("t6_mosi", mosi_cap2, 48'h1234_5678_9ABC);
    chk("t6_rx_data", rx_data2, {MSGID, 16'hBEEF});
    chk("t6_valid_cnt", nvalid2, 1);
    chk("t6_period_min", per_min, 10);
    chk("t6_period_max", per_max, 10);
    chk("t6_ssel_low", last_low2, 488);
    // Header differs only in bit 16
    reply2 = {32'h74697276, 16'hBEEF};
    run2(48'hFFFF_0000_8001);
    chk("t6_err_cnt", nerr2, 1);
    chk("t6_valid_still", nvalid2, 1);
    chk("t6_rx_data_kept", rx_data2, {MSGID, 16'hBEEF});

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
